fwd_scoreboard: RTL and testbench

Hazard and forwarding responder for the five-stage MIPS pipeline. It consumes the register-write broadcasts (destination address, Tnew, result data) that the E/M/W stages produce, and answers the D and E stages' operand requests. Answers are a stall, a forwarded operand, or the register-file value. It keeps its own E/M/W shadow of in-flight destinations and their countdowns, inserts a bubble entry on stall, and counts stall cycles.

---
 rtl/fwd_scoreboard.sv | 122 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding responder for a five-stage MIPS pipeline: shadows E/M/W
// destinations with their Tnew countdowns and answers D/E operand requests.
module fwd_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_rs_tuse,
    input  logic [1:0]  d_rt_tuse,
    input  logic [4:0]  d_wr_addr,
    input  logic [1:0]  d_wr_tnew,
    input  logic [31:0] d_rs_grf,
    input  logic [31:0] d_rt_grf,
    input  logic [31:0] e_wr_data,
    input  logic [31:0] m_wr_data,
    input  logic [31:0] w_wr_data,
    input  logic [31:0] e_rs_in,
    input  logic [31:0] e_rt_in,
    output logic        stall,
    output logic [31:0] d_rs_fwd,
    output logic [31:0] d_rt_fwd,
    output logic [31:0] e_rs_fwd,
    output logic [31:0] e_rt_fwd,
    output logic [31:0] stall_count
);

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] tnew;
    } slot_t;

    slot_t       e_q, e_d, m_q, m_d, w_q, w_d;
    logic [4:0]  e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Operand 0 is rs, operand 1 is rt; both are resolved by the same loop.
    logic [1:0][4:0]  d_src, e_src;
    logic [1:0][1:0]  d_tuse;
    logic [1:0][31:0] d_grf, d_fwd, e_in, e_fwd;
    logic [1:0]       hazard;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    assign d_src  = {d_rt, d_rs};
    assign d_tuse = {d_rt_tuse, d_rs_tuse};
    assign d_grf  = {d_rt_grf, d_rs_grf};
    assign e_src  = {e_rt_q, e_rs_q};
    assign e_in   = {e_rt_in, e_rs_in};

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        hazard = '0;
        d_fwd  = d_grf;
        e_fwd  = e_in;
        for (int i = 0; i < 2; i++) begin
            // Youngest match wins; a not-yet-ready match blocks older ready slots.
            if (d_src[i] != 5'd0 && e_q.addr == d_src[i]) begin
                hazard[i] = (e_q.tnew > d_tuse[i]);
                if (e_q.tnew == 2'd0) d_fwd[i] = e_wr_data;
            end else if (d_src[i] != 5'd0 && m_q.addr == d_src[i]) begin
                hazard[i] = (m_q.tnew > d_tuse[i]);
                if (m_q.tnew == 2'd0) d_fwd[i] = m_wr_data;
            end else if (d_src[i] != 5'd0 && w_q.addr == d_src[i]) begin
                hazard[i] = (w_q.tnew > d_tuse[i]);
                if (w_q.tnew == 2'd0) d_fwd[i] = w_wr_data;
            end

            if (e_src[i] != 5'd0 && m_q.addr == e_src[i]) begin
                if (m_q.tnew == 2'd0) e_fwd[i] = m_wr_data;
            end else if (e_src[i] != 5'd0 && w_q.addr == e_src[i]) begin
                e_fwd[i] = w_wr_data;
            end
        end
    end

    assign stall    = |hazard;
    assign d_rs_fwd = d_fwd[0];
    assign d_rt_fwd = d_fwd[1];
    assign e_rs_fwd = e_fwd[0];
    assign e_rt_fwd = e_fwd[1];

    always_comb begin
        if (stall) begin
            e_d    = '0;
            e_rs_d = 5'd0;
            e_rt_d = 5'd0;
        end else begin
            e_d    = '{addr: d_wr_addr, tnew: d_wr_tnew};
            e_rs_d = d_rs;
            e_rt_d = d_rt;
        end
        m_d           = '{addr: e_q.addr, tnew: sat_dec(e_q.tnew)};
        w_d           = '{addr: m_q.addr, tnew: sat_dec(m_q.tnew)};
        stall_count_d = stall ? stall_count_q + 32'd1 : stall_count_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, and every
    // register is cleared by the asynchronous reset so stall drops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q           <= '0;
            m_q           <= '0;
            w_q           <= '0;
            e_rs_q        <= 5'd0;
            e_rt_q        <= 5'd0;
            stall_count_q <= 32'd0;
        end else begin
            e_q           <= e_d;
            m_q           <= m_d;
            w_q           <= w_d;
            e_rs_q        <= e_rs_d;
            e_rt_q        <= e_rt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed hazard scenarios plus
// randomized traffic against an instruction-history reference model.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, d_wr_addr;
    logic [1:0]  d_rs_tuse, d_rt_tuse, d_wr_tnew;
    logic [31:0] d_rs_grf, d_rt_grf, e_wr_data, m_wr_data, w_wr_data, e_rs_in, e_rt_in;
    logic        stall;
    logic [31:0] d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd, stall_count;

    int n_vec = 0;
    int n_err = 0;

    fwd_scoreboard dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_wr_addr(d_wr_addr), .d_wr_tnew(d_wr_tnew),
        .d_rs_grf(d_rs_grf), .d_rt_grf(d_rt_grf),
        .e_wr_data(e_wr_data), .m_wr_data(m_wr_data), .w_wr_data(w_wr_data),
        .e_rs_in(e_rs_in), .e_rt_in(e_rt_in),
        .stall(stall), .d_rs_fwd(d_rs_fwd), .d_rt_fwd(d_rt_fwd),
        .e_rs_fwd(e_rs_fwd), .e_rt_fwd(e_rt_fwd), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: the last three instructions to enter E, indexed by age
    // (0 = in E, 1 = in M, 2 = in W), each with its Tnew at E entry.
    typedef struct {
        logic [4:0] addr;
        int         tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } instr_t;

    instr_t hist [3];
    int     exp_cnt;

    function automatic int youngest(input logic [4:0] r, input int from);
        for (int a = from; a < 3; a++)
            if (r != 5'd0 && hist[a].addr == r) return a;
        return -1;
    endfunction

    function automatic int remaining(input int a);
        int t;
        t = hist[a].tnew - a;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic [31:0] age_data(input int a);
        case (a)
            0:       return e_wr_data;
            1:       return m_wr_data;
            default: return w_wr_data;
        endcase
    endfunction

    function automatic logic op_stalls(input logic [4:0] r, input logic [1:0] tuse);
        int a;
        a = youngest(r, 0);
        return (a >= 0) && (remaining(a) > int'(tuse));
    endfunction

    function automatic logic [31:0] model_dfwd(input logic [4:0] r, input logic [31:0] grf);
        int a;
        a = youngest(r, 0);
        if (a >= 0 && remaining(a) == 0) return age_data(a);
        return grf;
    endfunction

    function automatic logic [31:0] model_efwd(input logic [4:0] r, input logic [31:0] held);
        int a;
        a = youngest(r, 1);
        if (a == 1) return (remaining(1) == 0) ? m_wr_data : held;
        if (a == 2) return w_wr_data;
        return held;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 3; a++) hist[a] = '{addr: 5'd0, tnew: 0, rs: 5'd0, rt: 5'd0};
        exp_cnt = 0;
    endtask

    task automatic model_step(input logic stalled);
        hist[2] = hist[1];
        hist[1] = hist[0];
        if (stalled) hist[0] = '{addr: 5'd0, tnew: 0, rs: 5'd0, rt: 5'd0};
        else         hist[0] = '{addr: d_wr_addr, tnew: int'(d_wr_tnew), rs: d_rs, rt: d_rt};
        if (stalled) exp_cnt++;
    endtask

    task automatic clear_inputs();
        d_rs = 0; d_rt = 0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
        d_wr_addr = 0; d_wr_tnew = 0;
        d_rs_grf = 0; d_rt_grf = 0; e_wr_data = 0; m_wr_data = 0; w_wr_data = 0;
        e_rs_in = 0; e_rt_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        d_rs = 5'd5; d_rs_tuse = 2'd0; d_rs_grf = 32'h11; e_rs_in = 32'h22;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall[%0d]: got %b want 0", k, stall); end
            n_vec++; if (d_rs_fwd !== 32'h11) begin n_err++; $display("FAIL reset_d_rs_fwd[%0d]: got %h want 11", k, d_rs_fwd); end
            n_vec++; if (e_rs_fwd !== 32'h22) begin n_err++; $display("FAIL reset_e_rs_fwd[%0d]: got %h want 22", k, e_rs_fwd); end
            n_vec++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL reset_count[%0d]: got %0d want 0", k, stall_count); end
            if (k == 0) begin tick(); reset = 1'b1; end
        end
        tick();
        n_vec++; if (stall !== 1'b0 || d_rs_fwd !== 32'h11) begin n_err++; $display("FAIL reset_release: stall %b fwd %h want 0/11", stall, d_rs_fwd); end
    endtask

    task automatic test_alu_e_forward();
        do_reset();
        d_wr_addr = 5'd8; d_wr_tnew = 2'd1; d_rs = 5'd1; d_rt = 5'd2;
        tick();
        d_wr_addr = 5'd10; d_wr_tnew = 2'd1; d_rs = 5'd8; d_rs_tuse = 2'd1; d_rt = 5'd0;
        d_rs_grf = 32'h55;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_no_stall: got %b want 0", stall); end
        n_vec++; if (d_rs_fwd !== 32'h55) begin n_err++; $display("FAIL alu_d_grf: got %h want 55", d_rs_fwd); end
        tick();
        clear_inputs();
        m_wr_data = 32'h1234; w_wr_data = 32'h9999; e_rs_in = 32'hDEAD; e_rt_in = 32'hBEEF;
        #1;
        n_vec++; if (e_rs_fwd !== 32'h1234) begin n_err++; $display("FAIL alu_e_rs_fwd: got %h want 1234", e_rs_fwd); end
        n_vec++; if (e_rt_fwd !== 32'hBEEF) begin n_err++; $display("FAIL alu_e_rt_fwd: got %h want beef", e_rt_fwd); end
    endtask

    task automatic test_load_use();
        do_reset();
        d_wr_addr = 5'd9; d_wr_tnew = 2'd2; d_rs = 5'd1;
        tick();
        d_wr_addr = 5'd0; d_wr_tnew = 2'd0; d_rs = 5'd9; d_rs_tuse = 2'd0; d_rt = 5'd0; d_rt_tuse = 2'd0;
        d_rs_grf = 32'h0BAD;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_stall[%0d]: got %b want 1", k, stall); end
            tick();
        end
        w_wr_data = 32'hCAFE; m_wr_data = 32'h1; e_wr_data = 32'h2;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_release: got %b want 0", stall); end
        n_vec++; if (stall_count !== 32'd2) begin n_err++; $display("FAIL load_count: got %0d want 2", stall_count); end
        n_vec++; if (d_rs_fwd !== 32'hCAFE) begin n_err++; $display("FAIL load_w_fwd: got %h want cafe", d_rs_fwd); end
    endtask

    task automatic test_branch_after_alu();
        do_reset();
        d_wr_addr = 5'd7; d_wr_tnew = 2'd1;
        tick();
        d_wr_addr = 5'd0; d_wr_tnew = 2'd0; d_rt = 5'd7; d_rt_tuse = 2'd0; d_rt_grf = 32'h3;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL branch_stall: got %b want 1", stall); end
        tick();
        m_wr_data = 32'h7777;
        #1;
        n_vec++; if (stall !== 1'b0 || d_rt_fwd !== 32'h7777) begin n_err++; $display("FAIL branch_m_fwd: stall %b fwd %h want 0/7777", stall, d_rt_fwd); end
    endtask

    task automatic test_youngest();
        do_reset();
        d_wr_addr = 5'd4; d_wr_tnew = 2'd1;
        tick();
        tick();
        d_wr_addr = 5'd0; d_wr_tnew = 2'd0;
        tick();
        d_rs = 5'd4; d_rs_tuse = 2'd0; d_rs_grf = 32'h0;
        w_wr_data = 32'hA; m_wr_data = 32'hB; e_wr_data = 32'hC;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL youngest_stall: got %b want 0", stall); end
        n_vec++; if (d_rs_fwd !== 32'hB) begin n_err++; $display("FAIL youngest_fwd: got %h want b", d_rs_fwd); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        d_wr_addr = 5'd0; d_wr_tnew = 2'd2;
        tick();
        d_wr_tnew = 2'd0; d_rs = 5'd0; d_rs_tuse = 2'd0; d_rs_grf = 32'h77; e_wr_data = 32'h88;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %b want 0", stall); end
        n_vec++; if (d_rs_fwd !== 32'h77) begin n_err++; $display("FAIL zero_fwd: got %h want 77", d_rs_fwd); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        d_wr_addr = 5'd9; d_wr_tnew = 2'd2;
        tick();
        d_wr_addr = 5'd0; d_wr_tnew = 2'd0; d_rs = 5'd9; d_rs_tuse = 2'd0;
        tick();
        n_vec++; if (stall !== 1'b1 || stall_count !== 32'd1) begin n_err++; $display("FAIL midstall_pre: stall %b count %0d want 1/1", stall, stall_count); end
        reset = 1'b0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL midstall_drop: got %b want 0", stall); end
        n_vec++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL midstall_count: got %0d want 0", stall_count); end
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_random();
        logic exp_s;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (!exp_s || c == 0) begin
                d_rs      = 5'($urandom_range(0, 3));
                d_rt      = 5'($urandom_range(0, 3));
                d_rs_tuse = 2'($urandom_range(0, 3));
                d_rt_tuse = 2'($urandom_range(0, 3));
                d_wr_addr = 5'($urandom_range(0, 3));
                d_wr_tnew = 2'($urandom_range(0, 3));
            end
            d_rs_grf = $urandom; d_rt_grf = $urandom;
            e_wr_data = $urandom; m_wr_data = $urandom; w_wr_data = $urandom;
            e_rs_in = $urandom; e_rt_in = $urandom;
            #3;
            exp_s = op_stalls(d_rs, d_rs_tuse) || op_stalls(d_rt, d_rt_tuse);
            n_vec++; if (stall !== exp_s) begin n_err++; $display("FAIL rnd_stall@%0d: got %b want %b", c, stall, exp_s); end
            n_vec++; if (d_rs_fwd !== model_dfwd(d_rs, d_rs_grf)) begin n_err++; $display("FAIL rnd_d_rs@%0d: got %h want %h", c, d_rs_fwd, model_dfwd(d_rs, d_rs_grf)); end
            n_vec++; if (d_rt_fwd !== model_dfwd(d_rt, d_rt_grf)) begin n_err++; $display("FAIL rnd_d_rt@%0d: got %h want %h", c, d_rt_fwd, model_dfwd(d_rt, d_rt_grf)); end
            n_vec++; if (e_rs_fwd !== model_efwd(hist[0].rs, e_rs_in)) begin n_err++; $display("FAIL rnd_e_rs@%0d: got %h want %h", c, e_rs_fwd, model_efwd(hist[0].rs, e_rs_in)); end
            n_vec++; if (e_rt_fwd !== model_efwd(hist[0].rt, e_rt_in)) begin n_err++; $display("FAIL rnd_e_rt@%0d: got %h want %h", c, e_rt_fwd, model_efwd(hist[0].rt, e_rt_in)); end
            n_vec++; if (stall_count !== 32'(exp_cnt)) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, stall_count, exp_cnt); end
            model_step(exp_s);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_e_forward();
        test_load_use();
        test_branch_after_alu();
        test_youngest();
        test_zero_reg();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
